// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and the datapath.
//   FWD_*        : forward-select encodings used by the E-stage operand muxes
//   div_state_t  : divider sequencer states
package hazard_ctrl_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/hazard_ctrl_div_seq.sv
// Divider sequencer: tracks the multi-cycle divide sitting in the E stage.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no divide in flight; a start raises div_busy this cycle
//   BUSY  | divide in progress, counter counts down to terminal count
//   DONE  | result valid this cycle (div_done), divide leaves E
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : divide instruction present in E
//   abort      : exception flush; returns to IDLE, suppresses div_done
//   div_busy   : divider occupying E (stall request)
//   div_done   : one-cycle result-valid pulse
module div_seq
   import hazard_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic abort,
   output logic div_busy,
   output logic div_done
);

   localparam int CW = $clog2(DIV_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);
   // Leaving BUSY as the counter steps onto 1 gives DIV_CYCLES-1 stalled
   // cycles in total (start cycle + BUSY cycles) before DONE.
   localparam logic [CW-1:0] CNT_LAST = CW'(2);

   div_state_t    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      div_busy  = 1'b0;
      div_done  = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               div_busy  = 1'b1;
               cnt_nxt   = CNT_LOAD;
               state_nxt = (DIV_CYCLES > 2) ? BUSY : DONE;
            end
         end
         BUSY: begin
            div_busy = 1'b1;
            cnt_nxt  = cnt - CW'(1);
            if (cnt == CNT_LAST) state_nxt = DONE;
         end
         DONE: begin
            // start is still high here for the same instruction; ignore it
            div_done  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
      if (abort) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         div_done  = 1'b0;
      end
      // start is combinational into div_busy, so mask it during reset too
      if (!rst_n) begin
         div_busy = 1'b0;
         div_done = 1'b0;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush/forward controller for the 5-stage pipeline.
// Holds no data; drives enable (via stallX) and flush of each pipeline register.
//
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   rsD/rtD, rsE/rtE              : source register indices in D and E
//   writeregE/M/W, regwriteE/M/W  : destination index and write enable per stage
//   memtoregE/M                   : load in E / M
//   branchD                       : branch or jr resolving in D
//   div_startE                    : divide instruction in E
//   excM                          : exception/eret committing in M (top priority)
//   stallF..stallW, flushD..flushW: pipeline register hold / clear
//   forwardAD/BD                  : D-stage compare operand taken from M
//   forwardAE/BE                  : E operand select (FWD_RF / FWD_M / FWD_W)
//   div_busy, div_done            : divider occupying E, result-valid pulse
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int REGW       = 5,
   parameter int DIV_CYCLES = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [REGW-1:0] rsD,
   input  logic [REGW-1:0] rtD,
   input  logic [REGW-1:0] rsE,
   input  logic [REGW-1:0] rtE,
   input  logic [REGW-1:0] writeregE,
   input  logic [REGW-1:0] writeregM,
   input  logic [REGW-1:0] writeregW,
   input  logic            regwriteE,
   input  logic            regwriteM,
   input  logic            regwriteW,
   input  logic            memtoregE,
   input  logic            memtoregM,
   input  logic            branchD,
   input  logic            div_startE,
   input  logic            excM,
   output logic            stallF,
   output logic            stallD,
   output logic            stallE,
   output logic            stallM,
   output logic            stallW,
   output logic            flushD,
   output logic            flushE,
   output logic            flushM,
   output logic            flushW,
   output logic            forwardAD,
   output logic            forwardBD,
   output logic [1:0]      forwardAE,
   output logic [1:0]      forwardBE,
   output logic            div_busy,
   output logic            div_done
);

   logic m_live, w_live, e_live;
   logic lwstall, branchstall, divstall;

   div_seq #(
      .DIV_CYCLES (DIV_CYCLES)
   ) u_div_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_startE),
      .abort    (excM),
      .div_busy (div_busy),
      .div_done (div_done)
   );

   // Register 0 is hardwired, so a write to it never produces a forward.
   assign m_live = regwriteM && (writeregM != '0);
   assign w_live = regwriteW && (writeregW != '0);
   assign e_live = regwriteE && (writeregE != '0);

   always_comb begin
      forwardAE = FWD_RF;
      if (m_live && writeregM == rsE)      forwardAE = FWD_M;
      else if (w_live && writeregW == rsE) forwardAE = FWD_W;
      forwardBE = FWD_RF;
      if (m_live && writeregM == rtE)      forwardBE = FWD_M;
      else if (w_live && writeregW == rtE) forwardBE = FWD_W;
   end

   assign forwardAD = m_live && (writeregM == rsD);
   assign forwardBD = m_live && (writeregM == rtD);

   assign lwstall = memtoregE && ((rtE == rsD) || (rtE == rtD));

   assign branchstall = branchD &&
      ((e_live && ((writeregE == rsD) || (writeregE == rtD))) ||
       (memtoregM && (writeregM != '0) &&
        ((writeregM == rsD) || (writeregM == rtD))));

   assign divstall = div_busy;

   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      stallM = 1'b0;
      stallW = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      flushM = 1'b0;
      flushW = 1'b0;
      if (!rst_n) begin
         // everything held low while in reset
      end else if (excM) begin
         flushD = 1'b1;
         flushE = 1'b1;
         flushM = 1'b1;
         flushW = 1'b1;
      end else if (divstall) begin
         // Freeze F/D/E around the divide and bubble M; flushE stays low so a
         // coincident load-use hazard cannot destroy the divide in E.
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         flushM = 1'b1;
      end else begin
         stallF = lwstall | branchstall;
         stallD = lwstall | branchstall;
         flushE = lwstall | branchstall;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   localparam int REGW = 5;
   localparam int D    = 4;

   typedef struct {
      logic [REGW-1:0] rsD, rtD, rsE, rtE, wE, wM, wW;
      logic            rwE, rwM, rwW, mrE, mrM, brD, start, exc;
   } st_t;

   typedef struct packed {
      logic [4:0] stall;
      logic [3:0] flush;
      logic [1:0] fwdd;
      logic [3:0] fwde;
      logic [1:0] div;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [REGW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic            regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
   logic            branchD, div_startE, excM;
   logic            stallF, stallD, stallE, stallM, stallW;
   logic            flushD, flushE, flushM, flushW;
   logic            forwardAD, forwardBD, div_busy, div_done;
   logic [1:0]      forwardAE, forwardBE;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   age = -1;      // edges since the divide's start cycle, -1 = no divide
   st_t  prev, zero_st;
   exp_t expq[$];

   always #5 clk = ~clk;

   hazard_ctrl #(.REGW(REGW), .DIV_CYCLES(D)) dut (
      .clk(clk), .rst_n(rst_n),
      .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
      .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
      .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
      .memtoregE(memtoregE), .memtoregM(memtoregM),
      .branchD(branchD), .div_startE(div_startE), .excM(excM),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
      .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
      .forwardAD(forwardAD), .forwardBD(forwardBD),
      .forwardAE(forwardAE), .forwardBE(forwardBE),
      .div_busy(div_busy), .div_done(div_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic apply(input st_t s);
      rsD = s.rsD; rtD = s.rtD; rsE = s.rsE; rtE = s.rtE;
      writeregE = s.wE; writeregM = s.wM; writeregW = s.wW;
      regwriteE = s.rwE; regwriteM = s.rwM; regwriteW = s.rwW;
      memtoregE = s.mrE; memtoregM = s.mrM; branchD = s.brD;
      div_startE = s.start; excM = s.exc;
   endtask

   function automatic logic [1:0] fwd_e(input st_t s, input logic [REGW-1:0] src);
      if (s.rwM && s.wM != 0 && s.wM == src) return 2'b10;
      if (s.rwW && s.wW != 0 && s.wW == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic exp_t model(input st_t s, input int a);
      exp_t e;
      bit lw, br, busy, done, hz;
      lw   = s.mrE && (s.rtE == s.rsD || s.rtE == s.rtD);
      br   = s.brD && ((s.rwE && s.wE != 0 && (s.wE == s.rsD || s.wE == s.rtD)) ||
                       (s.mrM && s.wM != 0 && (s.wM == s.rsD || s.wM == s.rtD)));
      busy = (a < 0) ? (s.start && !s.exc) : (a < D - 1);
      done = (a == D - 1) && !s.exc;
      hz   = lw || br;
      e.stall = 5'b0;
      e.flush = 4'b0;
      if (s.exc) e.flush = 4'b1111;
      else if (busy) begin
         e.stall = 5'b11100;   // F D E M W
         e.flush = 4'b0010;    // D E M W
      end else begin
         e.stall = {hz, hz, 3'b000};
         e.flush = {1'b0, hz, 2'b00};
      end
      e.fwdd = {s.rwM && s.wM != 0 && s.wM == s.rsD, s.rwM && s.wM != 0 && s.wM == s.rtD};
      e.fwde = {fwd_e(s, s.rsE), fwd_e(s, s.rtE)};
      e.div  = {busy, done};
      return e;
   endfunction

   // Advance the divider model across the edge that just happened.
   task automatic advance();
      if (prev.exc) age = -1;
      else if (age < 0) age = prev.start ? 1 : -1;
      else if (age == D - 1) age = -1;
      else age = age + 1;
   endtask

   task automatic step(input bit rnd, input st_t s_in);
      st_t s;
      @(posedge clk);
      cyc++;
      advance();
      #1;
      s = s_in;
      if (rnd) begin
         s.rsD = REGW'($urandom_range(0, 7)); s.rtD = REGW'($urandom_range(0, 7));
         s.rsE = REGW'($urandom_range(0, 7)); s.rtE = REGW'($urandom_range(0, 7));
         s.wE  = REGW'($urandom_range(0, 7)); s.wM  = REGW'($urandom_range(0, 7));
         s.wW  = REGW'($urandom_range(0, 7));
         s.rwE = 1'($urandom); s.rwM = 1'($urandom); s.rwW = 1'($urandom);
         s.mrE = ($urandom_range(0, 3) == 0); s.mrM = ($urandom_range(0, 3) == 0);
         s.brD = ($urandom_range(0, 2) == 0);
         s.start = (age >= 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
         s.exc = ($urandom_range(0, 19) == 0);
      end
      apply(s);
      expq.push_back(model(s, age));
      prev = s;
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, " stalls"},  {stallF, stallD, stallE, stallM, stallW}, 32'h0);
      check({name, " flushes"}, {flushD, flushE, flushM, flushW}, 32'h0);
      check({name, " div"},     {div_busy, div_done}, 32'h0);
   endtask

   // Monitor: one expected response per cycle, compared mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && expq.size() > 0) begin
         e = expq.pop_front();
         check("stalls",  {stallF, stallD, stallE, stallM, stallW}, 32'(e.stall));
         check("flushes", {flushD, flushE, flushM, flushW}, 32'(e.flush));
         check("fwd_d",   {forwardAD, forwardBD}, 32'(e.fwdd));
         check("fwd_e",   {forwardAE, forwardBE}, 32'(e.fwde));
         check("div",     {div_busy, div_done}, 32'(e.div));
      end
   end

   initial begin
      st_t s;
      zero_st = '{default: '0};
      prev = zero_st;

      // reset with hazards and a divide start presented: outputs must stay low
      rst_n = 1'b0;
      s = zero_st;
      s.mrE = 1'b1; s.rtE = 5'd8; s.rsD = 5'd8; s.start = 1'b1;
      apply(s);
      #3 check_reset_outputs("reset");
      #10 check_reset_outputs("reset hold");
      apply(zero_st);
      #9 rst_n = 1'b1;

      // forward priority: M beats W
      s = zero_st; s.rwM = 1; s.rwW = 1; s.wM = 5; s.wW = 5; s.rsE = 5;
      step(0, s);
      s.rsE = 0; s.wM = 0; s.wW = 0;
      step(0, s);

      // load-use for one cycle, then cleared
      s = zero_st; s.mrE = 1; s.rwE = 1; s.rtE = 8; s.rsD = 8;
      step(0, s);
      s.mrE = 0;
      step(0, s);

      // branch hazard against E, then the producer in M forwards
      s = zero_st; s.brD = 1; s.rwE = 1; s.wE = 3; s.rtD = 3;
      step(0, s);
      s = zero_st; s.brD = 1; s.rwM = 1; s.wM = 3; s.rtD = 3;
      step(0, s);

      // divide: start held while stalled and through DONE
      s = zero_st; s.start = 1;
      repeat (D) step(0, s);
      step(0, zero_st);

      // divide with a concurrent load-use hazard
      s = zero_st; s.start = 1; s.mrE = 1; s.rtE = 6; s.rsD = 6;
      repeat (D) step(0, s);
      s.start = 0;
      step(0, s);
      step(0, zero_st);

      // exception during BUSY (counter at 2): no div_done afterwards
      s = zero_st; s.start = 1;
      step(0, s);
      step(0, s);
      s.exc = 1;
      step(0, s);
      s.exc = 0; s.start = 0;
      repeat (D) step(0, s);

      // async reset in BUSY, asserted between edges
      s = zero_st; s.start = 1;
      step(0, s);
      step(0, s);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("async reset");
      @(posedge clk);
      #1 check_reset_outputs("async reset hold");
      apply(zero_st);
      prev = zero_st;
      age = -1;
      @(negedge clk);
      #1 rst_n = 1'b1;

      // randomized traffic
      repeat (2000) step(1, zero_st);

      repeat (4) begin
         if (expq.size() > 0) @(negedge clk);
      end
      #1;
      check("scoreboard drained", 32'(expq.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
